// File: rtl/gpu_l1_prt.sv
`default_nettype none
// ============================================================================
// Module   : gpu_l1_prt
// Purpose  : Pending-request table placed behind the L1 tag lookup. Tracks
//            outstanding line misses, merges duplicate misses, issues one
//            memory request per unique line, captures the fill response and
//            hands the filled line back to the L1 for install.
// Ports    : clk, rst_n            - clock, async active-low reset
//            miss_*                - miss input from L1 (valid/ready)
//            mem_req_*             - request to L2/memory (valid/ready)
//            mem_resp_*            - fill response from memory (valid/ready)
//            fill_*                - filled line back to L1 (valid/ready)
//            count, full           - occupancy (registered)
//            resp_err              - sticky: response for non-ISSUED entry
// Revision : 1.0 - initial release
// ============================================================================
module gpu_l1_prt #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 256,
    parameter int ENTRIES = 6,
    parameter int IDX_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [IDX_W-1:0]  mem_req_id,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [IDX_W-1:0]  mem_resp_id,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              mem_resp_ready,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    input  logic              fill_ready,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ISSUED  = 2'd2,
        ST_FILLING = 2'd3
    } entry_state_t;

    localparam logic [IDX_W:0] c_entries = (IDX_W+1)'(ENTRIES);

    entry_state_t      r_state [ENTRIES];
    logic [ADDR_W-1:0] r_addr  [ENTRIES];

    logic              r_req_hold;
    logic [IDX_W-1:0]  r_req_held_idx;
    logic              r_fill_valid;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [DATA_W-1:0] r_fill_data;
    logic [IDX_W-1:0]  r_fill_idx;
    logic [IDX_W:0]    r_count;
    logic              r_full;
    logic              r_resp_err;

    logic              w_match;
    logic              w_any_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_any_pend;
    logic [IDX_W-1:0]  w_pend_idx;
    logic [IDX_W-1:0]  w_req_idx;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_resp_hit;
    logic [ADDR_W-1:0] w_resp_addr;
    logic              w_alloc;
    logic              w_issue;
    logic              w_resp_accept;
    logic              w_resp_take;
    logic              w_fill_hs;
    logic [IDX_W:0]    w_count_nxt;

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        w_match     = 1'b0;
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_any_pend  = 1'b0;
        w_pend_idx  = '0;
        w_resp_hit  = 1'b0;
        w_resp_addr = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if ((r_state[i] == ST_PENDING || r_state[i] == ST_ISSUED) &&
                r_addr[i] == miss_addr)
                w_match = 1'b1;
            if (r_state[i] == ST_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == ST_PENDING) begin
                w_any_pend = 1'b1;
                w_pend_idx = IDX_W'(i);
            end
            if (mem_resp_id == IDX_W'(i)) begin
                w_resp_hit  = (r_state[i] == ST_ISSUED);
                w_resp_addr = r_addr[i];
            end
        end
    end

    // A stalled request keeps its entry even if a lower-index entry becomes
    // PENDING meanwhile; the held entry stays PENDING until it is issued.
    assign w_req_idx = r_req_hold ? r_req_held_idx : w_pend_idx;

    always_comb begin
        w_req_addr = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_req_idx == IDX_W'(i))
                w_req_addr = r_addr[i];
        end
    end

    assign miss_ready     = w_match | w_any_free;
    assign mem_req_valid  = w_any_pend;
    assign mem_req_addr   = w_req_addr;
    assign mem_req_id     = w_req_idx;
    assign w_fill_hs      = r_fill_valid & fill_ready;
    assign mem_resp_ready = ~r_fill_valid | w_fill_hs;

    assign w_alloc        = miss_valid & miss_ready & ~w_match;
    assign w_issue        = mem_req_valid & mem_req_ready;
    assign w_resp_accept  = mem_resp_valid & mem_resp_ready;
    assign w_resp_take    = w_resp_accept & w_resp_hit;
    assign w_count_nxt    = r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_fill_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= ST_FREE;
                r_addr[i]  <= '0;
            end
            r_req_hold     <= 1'b0;
            r_req_held_idx <= '0;
            r_fill_valid   <= 1'b0;
            r_fill_addr    <= '0;
            r_fill_data    <= '0;
            r_fill_idx     <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_resp_err     <= 1'b0;
        end else begin
            // Each event targets a distinct entry, so the updates never collide.
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_alloc && w_free_idx == IDX_W'(i)) begin
                    r_state[i] <= ST_PENDING;
                    r_addr[i]  <= miss_addr;
                end
                if (w_issue && w_req_idx == IDX_W'(i))
                    r_state[i] <= ST_ISSUED;
                if (w_resp_take && mem_resp_id == IDX_W'(i))
                    r_state[i] <= ST_FILLING;
                if (w_fill_hs && r_fill_idx == IDX_W'(i))
                    r_state[i] <= ST_FREE;
            end

            r_req_hold     <= mem_req_valid & ~mem_req_ready;
            r_req_held_idx <= w_req_idx;

            if (w_resp_take) begin
                r_fill_valid <= 1'b1;
                r_fill_addr  <= w_resp_addr;
                r_fill_data  <= mem_resp_data;
                r_fill_idx   <= mem_resp_id;
            end else if (w_fill_hs) begin
                r_fill_valid <= 1'b0;
            end

            if (w_resp_accept && !w_resp_hit)
                r_resp_err <= 1'b1;

            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_entries);
        end
    end

    assign fill_valid = r_fill_valid;
    assign fill_addr  = r_fill_addr;
    assign fill_data  = r_fill_data;
    assign count      = r_count;
    assign full       = r_full;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: doc/gpu_l1_prt.md
Name: gpu_l1_prt

Overview:
- Pending-request table that sits directly downstream of the L1 cache tag lookup.
- Accepts L1 miss addresses, merges duplicate misses, issues one memory request per unique line, and captures the 256-bit fill response.
- Hands the filled line back to the L1 for install and frees the entry on that handoff.
- Owns all outstanding-miss bookkeeping so the L1 lookup can stay single-cycle.

Parameters:
- ADDR_W, 13: line address (tag) width.
- DATA_W, 256: cache line width.
- ENTRIES, 6: number of PRT entries.
- IDX_W, 3: entry index width; must satisfy 2^IDX_W >= ENTRIES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- miss_valid  input  1  L1 presents a miss.
- miss_addr  input  ADDR_W  missing line address.
- miss_ready  output  1  PRT accepts the miss this cycle.
- mem_req_valid  output  1  request to L2/memory.
- mem_req_addr  output  ADDR_W  requested line.
- mem_req_id  output  IDX_W  PRT entry index used as tag.
- mem_req_ready  input  1  memory accepts request.
- mem_resp_valid  input  1  fill response present.
- mem_resp_id  input  IDX_W  entry index of response.
- mem_resp_data  input  DATA_W  returned line.
- mem_resp_ready  output  1  PRT accepts response.
- fill_valid  output  1  filled line available to L1.
- fill_addr  output  ADDR_W  line address of fill.
- fill_data  output  DATA_W  line data.
- fill_ready  input  1  L1 installs the fill.
- count  output  IDX_W+1  number of non-FREE entries.
- full  output  1  count == ENTRIES.
- resp_err  output  1  sticky: a response arrived for an entry not in ISSUED.

Behaviour:
- Reset (async, rst_n=0): all entries FREE; fill buffer empty; fill_valid=0, fill_addr=0, fill_data=0, count=0, full=0, resp_err=0.
- Reset mid-operation discards all outstanding entries and the fill buffer; late responses after reset set resp_err.
- Per-entry state machine:
  - FREE -> PENDING on allocate.
  - PENDING -> ISSUED on a mem request handshake.
  - ISSUED -> FILLING on response accept.
  - FILLING -> FREE on fill handshake.
- Match: miss_addr equals the addr of any entry in PENDING or ISSUED. FILLING entries never match.
- miss_ready (combinational) = match OR (any FREE entry). Evaluated on current state only; no bypass from an entry freed in the same cycle.
- Accepted miss with match: merge; no allocation, no new request, count unchanged.
- Accepted miss without match: allocate the lowest-index FREE entry, store addr, state PENDING.
- mem_req_valid (combinational) = any PENDING entry. Addr/id come from the lowest-index PENDING entry and are held stable while valid and not ready.
- Handshake (mem_req_valid & mem_req_ready): that entry becomes ISSUED. At most one issue per cycle.
- A miss allocated in cycle N can be issued no earlier than cycle N+1.
- mem_resp_ready = fill buffer empty OR fill handshake occurring this cycle.
- Response accept with entry[id] ISSUED: capture data and addr into the fill buffer; entry becomes FILLING; fill_valid=1 from the next cycle.
- Response accept with entry[id] not ISSUED: data dropped, no state change, resp_err set until reset.
- fill_valid/fill_addr/fill_data are registered and held stable until fill_ready.
- On fill handshake: entry becomes FREE, buffer is emptied unless refilled in the same cycle (back-to-back fills allowed, one per cycle).
- count and full are registered. Simultaneous allocate + free in one cycle leaves count unchanged.
- Simultaneous miss, issue, response and fill in one cycle are all legal and independent, provided each targets a distinct entry.

Test Plan:
- Single miss: addr 0x0A5 accepted; mem_req id=0 addr=0x0A5 next cycle; resp id=0 data=0xDEAD.. -> fill_valid one cycle later with addr 0x0A5; count returns 1->0.
- Merge: misses 0x010, 0x010, 0x011 -> exactly two mem requests (ids 0,1); count=2; both miss handshakes complete.
- Full: six unique misses with mem_req_ready=0 -> full=1, count=6. Seventh unique miss -> miss_ready=0. Seventh miss matching entry 3 -> miss_ready=1 and merged.
- Out-of-order responses: issue ids 0,1,2; respond 2,0,1 -> fills in order 2,0,1 with correct addr/data; entries freed accordingly.
- Backpressure: fill_ready=0 with a second response pending -> mem_resp_ready=0, fill outputs stable. Raise fill_ready -> second response accepted the same cycle.
- Error/reset: response for a FREE id -> resp_err=1, no fill. Assert rst_n=0 mid-flight -> count=0, fill_valid=0 immediately.
